// File: rtl/dmem_access_unit.sv
// MEM-stage data RAM initiator: byte/half/word loads and stores on a word-wide
// RAM with 1-cycle read latency; sub-word stores use read-modify-write.
module dmem_access_unit #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [15:0]       wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              capture;

  logic [ADDR_W-1:0] req_word_addr;
  logic              req_misaligned;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] rmw_word;
  logic              unused_addr_bits;

  // Upper byte-address bits wrap within the RAM depth.
  assign req_word_addr    = req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));

  // Lane selection and extension of the returned load word.
  always_comb begin
    byte_sel = ram_dout[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = ram_dout;
    endcase
  end

  // Merge store data into the word read back for a sub-word store.
  always_comb begin
    rmw_word = ram_dout;
    if (size_q == 2'b00) begin
      rmw_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      rmw_word[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (capture) begin
        waddr_q  <= req_word_addr;
        lane_q   <= req_addr[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        wdata_q  <= req_wdata[15:0];
      end
    end
  end

  // Next state and Mealy outputs; IDLE drives the RAM straight from the request.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    misalign  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_word_addr;
    ram_din   = '0;
    rdata_d   = rdata_q;
    capture   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_misaligned) begin
            rsp_valid = 1'b1;
            misalign  = 1'b1;
            rdata_d   = '0;
          end else if (req_we && req_size[1]) begin
            ram_we    = 1'b1;
            ram_din   = req_wdata;
            rsp_valid = 1'b1;
          end else begin
            stall   = 1'b1;
            capture = 1'b1;
            state_d = req_we ? RMW_WR : LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        ram_addr  = waddr_q;
        rsp_valid = 1'b1;
        rdata_d   = load_ext;
        state_d   = IDLE;
      end
      RMW_WR: begin
        ram_addr  = waddr_q;
        ram_din   = rmw_word;
        ram_we    = 1'b1;
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset cycle: quiet outputs, abandon any access in flight.
    if (!rst_n) begin
      state_d   = IDLE;
      stall     = 1'b0;
      rsp_valid = 1'b0;
      misalign  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      rdata_d   = '0;
      capture   = 1'b0;
    end
  end

  assign rsp_rdata = rdata_d;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: behavioural 1-cycle-latency RAM plus a queue of
// expected responses checked as each access completes.
module tb_dmem_access_unit;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_we, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              stall, rsp_valid, misalign, ram_we;
  logic [31:0]       rsp_rdata, ram_din, ram_dout;
  logic [ADDR_W-1:0] ram_addr;

  logic [31:0] mem [DEPTH];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          stalls;
  } exp_t;
  exp_t sb[$];

  int nchk = 0;
  int nerr = 0;

  dmem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .misalign(misalign), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  // Drive one request and observe it until rsp_valid (bounded).
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] o_rdata, output logic o_mis,
                         output int o_stalls, output int o_we_cnt,
                         output logic [ADDR_W-1:0] o_we_addr,
                         output logic [31:0] o_we_din, output logic o_to);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    o_stalls = 0; o_we_cnt = 0; o_to = 1'b1;
    o_rdata = '0; o_mis = 1'b0; o_we_addr = '0; o_we_din = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ram_we) begin
        o_we_cnt++; o_we_addr = ram_addr; o_we_din = ram_din;
      end
      if (rsp_valid) begin
        o_rdata = rsp_rdata; o_mis = misalign; o_to = 1'b0;
        break;
      end
      if (stall) o_stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nchk++;
    if ({stall, rsp_valid, misalign, ram_we} !== 4'b0000 || rsp_rdata !== 32'h0 ||
        ram_din !== 32'h0 || ram_addr !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got stall=%b rsp=%b mis=%b we=%b rdata=%h din=%h addr=%h, want all 0",
               stall, rsp_valid, misalign, ram_we, rsp_rdata, ram_din, ram_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd, din; logic mis, to; int st, wc; logic [ADDR_W-1:0] wa;
    exp_t e;
    sb.push_back('{32'h0, 1'b0, 0});
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis, st, wc, wa, din, to);
    e = sb.pop_front();
    nchk++;
    if (to || wc != 1 || wa !== 10'd4 || din !== 32'hDEADBEEF || st != e.stalls || mis !== e.mis) begin
      nerr++;
      $display("FAIL word_store: to=%b we_cnt=%0d addr=%0d din=%h stalls=%0d mis=%b, want 1/4/DEADBEEF/0/0",
               to, wc, wa, din, st, mis);
    end
    sb.push_back('{32'hDEADBEEF, 1'b0, 1});
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, st, wc, wa, din, to);
    e = sb.pop_front();
    nchk++;
    if (to || rd !== e.rdata || st != e.stalls || mis !== e.mis || wc != 0) begin
      nerr++;
      $display("FAIL word_load: rdata=%h stalls=%0d mis=%b we_cnt=%0d to=%b, want %h/%0d",
               rd, st, mis, wc, to, e.rdata, e.stalls);
    end
    // Held value after the response cycle.
    @(negedge clk);
    nchk++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rdata_hold: rdata=%h rsp_valid=%b, want DEADBEEF/0", rsp_rdata, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_subword_load();
    logic [1:0]  sz [7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg [7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [7]  = '{32'h23, 32'h20, 32'h21, 32'h22, 32'h23, 32'h22, 32'h20};
    logic [31:0] ex [7]  = '{32'h11, 32'h1, 32'h7F, 32'hFFFFFFFF, 32'h80, 32'hFFFF80FF, 32'h7F01};
    logic [31:0] rd, din; logic mis, to; int st, wc; logic [ADDR_W-1:0] wa;
    exp_t e;
    mem[8] = 32'h11223344;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) mem[8] = 32'h80FF7F01;
      sb.push_back('{ex[i], 1'b0, 1});
      run_req(1'b0, sz[i], sg[i], ad[i], 32'h0, rd, mis, st, wc, wa, din, to);
      e = sb.pop_front();
      nchk++;
      if (to || rd !== e.rdata || st != e.stalls || mis !== e.mis || wc != 0) begin
        nerr++;
        $display("FAIL subword_load[%0d]: rdata=%h stalls=%0d mis=%b to=%b, want %h/%0d",
                 i, rd, st, mis, to, e.rdata, e.stalls);
      end
    end
  endtask

  task automatic test_rmw_store();
    logic [1:0]  sz [2] = '{2'b00, 2'b01};
    logic [31:0] ad [2] = '{32'h31, 32'h32};
    logic [31:0] wd [2] = '{32'hFFFFFFAA, 32'h1234BEEF};
    logic [31:0] ex [2] = '{32'h1122AA44, 32'hBEEFAA44};
    logic [31:0] rd, din; logic mis, to; int st, wc; logic [ADDR_W-1:0] wa;
    exp_t e;
    mem[12] = 32'h11223344;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{ex[i], 1'b0, 1});
      run_req(1'b1, sz[i], 1'b0, ad[i], wd[i], rd, mis, st, wc, wa, din, to);
      e = sb.pop_front();
      nchk++;
      if (to || wc != 1 || wa !== 10'd12 || din !== e.rdata || st != e.stalls || mis !== e.mis) begin
        nerr++;
        $display("FAIL rmw_store[%0d]: we_cnt=%0d addr=%0d din=%h stalls=%0d to=%b, want 1/12/%h/%0d",
                 i, wc, wa, din, st, to, e.rdata, e.stalls);
      end
    end
    nchk++;
    if (mem[12] !== 32'hBEEFAA44) begin
      nerr++;
      $display("FAIL rmw_final: mem=%h, want BEEFAA44", mem[12]);
    end
  endtask

  task automatic test_misalign();
    logic        we [2] = '{1'b0, 1'b1};
    logic [1:0]  sz [2] = '{2'b01, 2'b10};
    logic [31:0] ad [2] = '{32'h05, 32'h06};
    logic [31:0] rd, din; logic mis, to; int st, wc; logic [ADDR_W-1:0] wa;
    exp_t e;
    mem[1] = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{32'h0, 1'b1, 0});
      run_req(we[i], sz[i], 1'b0, ad[i], 32'h55555555, rd, mis, st, wc, wa, din, to);
      e = sb.pop_front();
      nchk++;
      if (to || mis !== e.mis || rd !== e.rdata || st != e.stalls || wc != 0) begin
        nerr++;
        $display("FAIL misalign[%0d]: mis=%b rdata=%h stalls=%0d we_cnt=%0d to=%b, want 1/0/0/0",
                 i, mis, rd, st, wc, to);
      end
    end
    nchk++;
    if (mem[1] !== 32'hCAFEF00D) begin
      nerr++;
      $display("FAIL misalign_mem: mem=%h, want CAFEF00D", mem[1]);
    end
  endtask

  task automatic test_reset_in_rmw();
    logic [31:0] rd, din; logic mis, to; int st, wc; logic [ADDR_W-1:0] wa;
    exp_t e;
    mem[20] = 32'h55667788;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h51; req_wdata = 32'h99;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    nchk++;
    if (ram_we !== 1'b0 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rmw_cycle: we=%b stall=%b rsp=%b, want 0/0/0", ram_we, stall, rsp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    nchk++;
    if (stall !== 1'b0 || rsp_valid !== 1'b0 || mem[20] !== 32'h55667788) begin
      nerr++;
      $display("FAIL reset_rmw_after: stall=%b rsp=%b mem=%h, want 0/0/55667788",
               stall, rsp_valid, mem[20]);
    end
    @(posedge clk); #1;
    sb.push_back('{32'h55667788, 1'b0, 1});
    run_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, rd, mis, st, wc, wa, din, to);
    e = sb.pop_front();
    nchk++;
    if (to || rd !== e.rdata || st != e.stalls) begin
      nerr++;
      $display("FAIL reset_rmw_idle_load: rdata=%h stalls=%0d to=%b, want %h/%0d",
               rd, st, to, e.rdata, e.stalls);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, din; logic mis, to; int st, wc; logic [ADDR_W-1:0] wa;
    exp_t e;
    sb.push_back('{32'hA5A5_0F0F, 1'b0, 0});
    run_req(1'b1, 2'b11, 1'b0, (32'd1 << (ADDR_W + 2)) + 32'h8, 32'hA5A5_0F0F,
            rd, mis, st, wc, wa, din, to);
    e = sb.pop_front();
    nchk++;
    if (to || wc != 1 || wa !== 10'd2 || din !== e.rdata || st != e.stalls || mem[2] !== e.rdata) begin
      nerr++;
      $display("FAIL addr_wrap: we_cnt=%0d addr=%0d din=%h mem=%h stalls=%0d, want 1/2/%h",
               wc, wa, din, mem[2], st, e.rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h44; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    test_reset();
    req_valid = 1'b0;
    @(posedge clk); #1;
    test_word_rw();
    test_subword_load();
    test_rmw_store();
    test_misalign();
    test_reset_in_rmw();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
